// File: rtl/link_monitor_pkg.sv
// Shared state encodings, timer width and default timing constants for the
// link monitor and its timer.
package link_monitor_pkg;

    localparam int TIMER_W = 20;

    localparam logic [TIMER_W-1:0] DEFAULT_STABLE_CYCLES  = 20'd1250;
    localparam logic [TIMER_W-1:0] DEFAULT_LOCK_TIMEOUT   = 20'd125000;
    localparam logic [TIMER_W-1:0] DEFAULT_RESTART_CYCLES = 20'd8;
    localparam logic [TIMER_W-1:0] TIMER_ONE              = 20'd1;

    typedef enum logic [2:0] {
        ST_DOWN      = 3'd0,
        ST_QUALIFY   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_UP        = 3'd3,
        ST_BACKOFF   = 3'd4
    } state_t;

    // The descrambler runs only while we are waiting for or holding lock.
    function automatic logic enables_desc(input state_t s);
        return (s == ST_WAIT_LOCK) || (s == ST_UP);
    endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter used for every timed phase of the link monitor.
// Holds at zero instead of wrapping.
module link_timer
    import link_monitor_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               decrement,
    output logic [TIMER_W-1:0] value,
    output logic               zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (decrement && (value != '0)) begin
            value <= value - TIMER_ONE;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/link_monitor.sv
// Link bring-up monitor: qualifies signal_detect, enables the descrambler,
// waits for lock with timeout/backoff, and counts lock losses.
module link_monitor
    import link_monitor_pkg::*;
#(
    parameter logic [TIMER_W-1:0] STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
    parameter logic [TIMER_W-1:0] LOCK_TIMEOUT   = DEFAULT_LOCK_TIMEOUT,
    parameter logic [TIMER_W-1:0] RESTART_CYCLES = DEFAULT_RESTART_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_detect,
    input  logic       locked,
    input  logic       test_mode_req,
    input  logic       clear_count,
    output logic       desc_enable,
    output logic       desc_test_mode,
    output logic       link_status,
    output logic [2:0] state,
    output logic [7:0] lock_loss_count
);

    state_t             cur_state;
    state_t             next_state;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_dec;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;
    logic               lock_lost;
    logic [7:0]         count_next;

    link_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .decrement  (timer_dec),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state       = cur_state;
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_dec        = 1'b0;
        if ((cur_state != ST_DOWN) && !signal_detect) begin
            next_state = ST_DOWN;
        end else begin
            unique case (cur_state)
                ST_DOWN: begin
                    if (signal_detect) begin
                        next_state       = ST_QUALIFY;
                        timer_load       = 1'b1;
                        timer_load_value = STABLE_CYCLES - TIMER_ONE;
                    end
                end
                ST_QUALIFY: begin
                    if (timer_zero) begin
                        next_state       = ST_WAIT_LOCK;
                        timer_load       = 1'b1;
                        timer_load_value = LOCK_TIMEOUT - TIMER_ONE;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked) begin
                        next_state = ST_UP;
                    end else if (timer_zero) begin
                        next_state       = ST_BACKOFF;
                        timer_load       = 1'b1;
                        timer_load_value = RESTART_CYCLES - TIMER_ONE;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!locked) begin
                        next_state       = ST_BACKOFF;
                        timer_load       = 1'b1;
                        timer_load_value = RESTART_CYCLES - TIMER_ONE;
                    end
                end
                ST_BACKOFF: begin
                    if (timer_zero) begin
                        next_state       = ST_WAIT_LOCK;
                        timer_load       = 1'b1;
                        timer_load_value = LOCK_TIMEOUT - TIMER_ONE;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                default: next_state = ST_DOWN;
            endcase
        end
    end

    // A clear coinciding with a loss still records that one loss.
    assign lock_lost = (cur_state == ST_UP) && (next_state != ST_UP);

    always_comb begin
        count_next = lock_loss_count;
        if (clear_count) begin
            count_next = lock_lost ? 8'd1 : 8'd0;
        end else if (lock_lost && (lock_loss_count != 8'hff)) begin
            count_next = lock_loss_count + 8'd1;
        end
    end

    // Outputs are decoded from next_state so they are registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state       <= ST_DOWN;
            desc_enable     <= 1'b0;
            link_status     <= 1'b0;
            desc_test_mode  <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            cur_state       <= next_state;
            desc_enable     <= enables_desc(next_state);
            link_status     <= (next_state == ST_UP);
            lock_loss_count <= count_next;
            if (!enables_desc(next_state)) begin
                desc_test_mode <= test_mode_req;
            end
        end
    end

    assign state = cur_state;

endmodule
